// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: sequences relax/fire windows, majority-votes NVOTE arbiter samples.
// Optional macro APUF_STABILITY_EN adds the unanimous-vote "stable" flag; otherwise stable is tied low.
module apuf_eval_ctrl #(
    parameter int CHAL_W     = 64,
    parameter int SETTLE_CYC = 8,
    parameter int NVOTE      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_in,
    output logic              busy,
    output logic [CHAL_W-1:0] chal_out,
    output logic              launch,
    input  logic              arb_q,
    output logic              resp,
    output logic [7:0]        ones,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              stable
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RELAX = 3'd2,
        FIRE  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [8:0] RELAX_LAST = 9'(SETTLE_CYC - 1);
    localparam logic [8:0] FIRE_LAST  = 9'(SETTLE_CYC + 1);
    localparam logic [7:0] NVOTE_L    = 8'(NVOTE);
    localparam logic [7:0] MAJ_L      = 8'((NVOTE - 1) / 2);

    state_t            state_reg, state_next;
    logic [8:0]        phase_cnt_reg;
    logic [7:0]        vote_cnt_reg;
    logic [7:0]        ones_reg;
    logic [CHAL_W-1:0] chal_reg;
    logic              launch_reg, launch_next;
    logic              resp_reg;
    logic              arb_meta_reg, arb_sync_reg;

    logic              accept;
    logic              fire_end;
    logic              last_vote;
    logic [7:0]        ones_inc;
    logic [7:0]        vote_inc;

    assign accept    = (state_reg == IDLE) && start;
    assign fire_end  = (state_reg == FIRE) && (phase_cnt_reg == FIRE_LAST);
    assign vote_inc  = vote_cnt_reg + 8'd1;
    assign last_vote = (vote_inc == NVOTE_L);
    // Saturating add so a pathological vote count can never wrap to a small value.
    assign ones_inc  = (arb_sync_reg && (ones_reg != 8'hFF)) ? ones_reg + 8'd1 : ones_reg;

    // arb_q is the arbiter latch output and is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_meta_reg <= 1'b0;
            arb_sync_reg <= 1'b0;
        end else begin
            arb_meta_reg <= arb_q;
            arb_sync_reg <= arb_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = RELAX;
            RELAX:   if (phase_cnt_reg == RELAX_LAST) state_next = FIRE;
            FIRE:    if (phase_cnt_reg == FIRE_LAST) state_next = last_vote ? DONE : RELAX;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_reg != IDLE);
        resp_valid  = (state_reg == DONE);
        launch_next = (state_next == FIRE);
    end

    // launch comes straight from a flop so the delay chain never sees decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            launch_reg <= 1'b0;
        end else begin
            launch_reg <= launch_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            phase_cnt_reg <= '0;
        end else if ((state_reg == RELAX) || (state_reg == FIRE)) begin
            phase_cnt_reg <= phase_cnt_reg + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chal_reg     <= '0;
            ones_reg     <= '0;
            vote_cnt_reg <= '0;
            resp_reg     <= 1'b0;
        end else if (accept) begin
            chal_reg     <= chal_in;
            ones_reg     <= '0;
            vote_cnt_reg <= '0;
        end else if (fire_end) begin
            ones_reg     <= ones_inc;
            vote_cnt_reg <= vote_inc;
            if (last_vote) begin
                resp_reg <= (ones_inc > MAJ_L);
            end
        end
    end

`ifdef APUF_STABILITY_EN
    logic stable_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_reg <= 1'b0;
        end else if (fire_end && last_vote) begin
            stable_reg <= (ones_inc == 8'd0) || (ones_inc == NVOTE_L);
        end
    end

    assign stable = stable_reg;
`else
    assign stable = 1'b0;
`endif

    assign chal_out = chal_reg;
    assign launch   = launch_reg;
    assign resp     = resp_reg;
    assign ones     = ones_reg;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl (SETTLE_CYC=2, NVOTE=3): timing model plus directed evaluations.
module tb_apuf_eval_ctrl;

    localparam int S     = 2;
    localparam int N     = 3;
    localparam int CW    = 16;
    localparam int ROUND = 2 * S + 2;
    localparam int LAT   = 2 + N * ROUND;
`ifdef APUF_STABILITY_EN
    localparam bit STAB = 1'b1;
`else
    localparam bit STAB = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] chal_in;
    logic          busy;
    logic [CW-1:0] chal_out;
    logic          launch;
    logic          arb_q;
    logic          resp;
    logic [7:0]    ones;
    logic          resp_valid;
    logic          resp_ready;
    logic          stable;

    apuf_eval_ctrl #(
        .CHAL_W    (CW),
        .SETTLE_CYC(S),
        .NVOTE     (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chal_in   (chal_in),
        .busy      (busy),
        .chal_out  (chal_out),
        .launch    (launch),
        .arb_q     (arb_q),
        .resp      (resp),
        .ones      (ones),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .stable    (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: an evaluation is described only by its accept cycle and the votes seen so far.
    bit            m_init   = 1'b0;
    bit            m_active = 1'b0;
    int            m_t0     = 0;
    logic [CW-1:0] m_chal   = '0;
    int            m_ones   = 0;
    bit            m_resp   = 1'b0;
    bit            m_stable = 1'b0;

    always @(posedge clk) begin : model
        int rel;
        int nv;
        cyc <= cyc + 1;
        rel = cyc - m_t0;
        nv  = (m_ones + int'(arb_q) > 255) ? 255 : m_ones + int'(arb_q);
        if (rst) begin
            m_init   <= 1'b1;
            m_active <= 1'b0;
            m_chal   <= '0;
            m_ones   <= 0;
            m_resp   <= 1'b0;
            m_stable <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_t0     <= cyc;
                m_chal   <= chal_in;
                m_ones   <= 0;
            end
        end else begin
            if (rel >= 2 && rel < LAT && ((rel - 2) % ROUND) == ROUND - 1) begin
                m_ones <= nv;
                if (rel == LAT - 1) begin
                    m_resp   <= (nv > (N - 1) / 2);
                    m_stable <= STAB && (nv == 0 || nv == N);
                end
            end
            if (rel >= LAT && resp_ready) m_active <= 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        int rel;
        if (m_init) begin
            rel = cyc - m_t0;
            chk("busy", 64'(busy), 64'(m_active));
            chk("launch", 64'(launch),
                64'(m_active && rel >= 2 && rel < LAT && ((rel - 2) % ROUND) >= S));
            chk("resp_valid", 64'(resp_valid), 64'(m_active && rel >= LAT));
            chk("chal_out", 64'(chal_out), 64'(m_chal));
            chk("ones", 64'(ones), 64'(m_ones));
            chk("resp", 64'(resp), 64'(m_resp));
            chk("stable", 64'(stable), 64'(m_stable));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pat[k] is the arbiter level during round k; rst_at > 0 aborts the run at that cycle.
    task automatic run_eval(input int id, input logic [CW-1:0] chal, input logic [2:0] pat,
                            input int hold, input bit glitch, input int rst_at,
                            input int e_ones, input bit e_resp);
        int  lat;
        bit  aborted;
        lat     = -1;
        aborted = 1'b0;
        start      = 1'b1;
        chal_in    = chal;
        resp_ready = (hold == 0);
        step();
        start = 1'b0;
        for (int r = 1; r < 100; r++) begin
            if (resp_valid) begin
                lat = r;
                break;
            end
            if (r >= 2 && ((r - 2) % ROUND) == 0 && ((r - 2) / ROUND) < N)
                arb_q = pat[(r - 2) / ROUND];
            start = glitch && (r == 5);
            if (start) chal_in = ~chal;
            rst = (r == rst_at);
            step();
            if (rst) begin
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            chk("abort_launch", 64'(launch), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_ones", 64'(ones), 64'd0);
            chk("abort_valid", 64'(resp_valid), 64'd0);
            $display("txn %0d chal=%h aborted by reset", id, chal);
            return;
        end
        chk("latency", 64'(lat), 64'(LAT));
        chk("lit_ones", 64'(ones), 64'(e_ones));
        chk("lit_resp", 64'(resp), 64'(e_resp));
        chk("lit_chal", 64'(chal_out), 64'(chal));
        chk("lit_stable", 64'(stable), 64'(STAB && (e_ones == 0 || e_ones == N)));
        $display("txn %0d chal=%h lat=%0d resp=%b ones=%0d stable=%b", id, chal_out, lat, resp, ones, stable);
        for (int h = 0; h < hold; h++) step();
        if (hold > 0) begin
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_ones", 64'(ones), 64'(e_ones));
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        step();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        chal_in    = '0;
        arb_q      = 1'b0;
        resp_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_chal", 64'(chal_out), 64'd0);
        chk("rst_ones", 64'(ones), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_launch", 64'(launch), 64'd0);
        step();

        run_eval(1, 16'hFFFF, 3'b111, 0, 1'b0, 0, 3, 1'b1);
        run_eval(2, 16'hA5C3, 3'b101, 0, 1'b0, 0, 2, 1'b1);
        run_eval(3, 16'h0F0F, 3'b100, 10, 1'b0, 0, 1, 1'b0);
        run_eval(4, 16'h1234, 3'b011, 0, 1'b1, 0, 2, 1'b1);
        run_eval(5, 16'h5555, 3'b001, 0, 1'b0, 10, 0, 1'b0);
        run_eval(6, 16'h00FF, 3'b000, 0, 1'b0, 0, 0, 1'b0);
        run_eval(7, 16'hC0DE, 3'b110, 2, 1'b0, 0, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
